// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port for the AES-128 key schedule.
interface aes_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;
  logic         keys_valid;

  modport master (
    output key_in, key_valid, rk_addr,
    input  key_ready, rk_out, busy, done, keys_valid
  );

  modport slave (
    input  key_in, key_valid, rk_addr,
    output key_ready, rk_out, busy, done, keys_valid
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry table,
// with a registered random-access read port.
module aes_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic               clk,
  input logic               reset,
  aes_key_schedule_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  logic [1:0]   state;
  logic [3:0]   rnd;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] rd_data;
  logic         done_pulse;
  logic         table_ok;

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] b;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // rnd is 0 outside EXPAND; clamp so the previous-key index stays in the table.
  assign prev_idx = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;

  // Single-round expansion of rk[rnd-1] with Rcon(rnd).
  always_comb begin
    prev    = rk[prev_idx];
    rot     = {prev[23:0], prev[31:24]};
    sub     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    temp    = sub ^ {rcon(rnd), 24'h000000};
    n0      = prev[127:96] ^ temp;
    n1      = prev[95:64] ^ n0;
    n2      = prev[63:32] ^ n1;
    n3      = prev[31:0] ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  // FSM, round counter, key table and registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rnd        <= 4'd0;
      rd_data    <= '0;
      done_pulse <= 1'b0;
      table_ok   <= 1'b0;
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) rk[i] <= '0;
    end else begin
      done_pulse <= 1'b0;
      rd_data    <= (bus.rk_addr <= LAST_RND) ? rk[bus.rk_addr] : '0;
      case (state)
        IDLE, DONE: begin
          if (bus.key_valid) begin
            rk[0]    <= bus.key_in;
            rnd      <= 4'd1;
            table_ok <= 1'b0;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
          rk[rnd] <= next_rk;
          if (rnd == LAST_RND) begin
            rnd        <= 4'd0;
            state      <= DONE;
            done_pulse <= 1'b1;
            table_ok   <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is held so a coincident key is never seen as accepted.
  assign bus.key_ready  = reset && (state != EXPAND);
  assign bus.busy       = (state == EXPAND);
  assign bus.rk_out     = rd_data;
  assign bus.done       = done_pulse;
  assign bus.keys_valid = table_ok;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-level FIPS-197 model.
module tb_aes_key_schedule;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];

  aes_key_schedule_if bus ();

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xtime(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Textbook 44-word expansion, regrouped into 11 round keys.
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
  endtask

  task automatic sweep(input bit all_zero);
    for (int a = 0; a < 16; a++) begin
      bus.rk_addr = 4'(a);
      step();
      if (all_zero || a > 10) check($sformatf("rk_out[%0d]", a), bus.rk_out, '0);
      else check($sformatf("rk_out[%0d]", a), bus.rk_out, exp_rk[a]);
    end
  endtask

  // Key must already be presented; edge N is the first step taken here.
  task automatic expand_and_check(input logic [127:0] key, input bit hold, input bit chain,
                                  input logic [127:0] nxt);
    int busy_cnt;
    compute_model(key);
    step();
    if (hold) bus.key_in = ~key;
    else bus.key_valid = 1'b0;
    check("busy_start", bus.busy, 1'b1);
    check("ready_start", bus.key_ready, 1'b0);
    check("kv_drop", bus.keys_valid, 1'b0);
    busy_cnt = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.busy) busy_cnt++;
      if (k < 10) begin
        if (bus.done !== 1'b0) check("done_early", bus.done, 1'b0);
      end
    end
    check("busy_cycles", 128'(busy_cnt), 128'd10);
    check("done_pulse", bus.done, 1'b1);
    check("kv_set", bus.keys_valid, 1'b1);
    check("ready_done", bus.key_ready, 1'b1);
    if (chain) begin
      present(nxt);
    end else begin
      bus.key_valid = 1'b0;
      step();
      check("done_clear", bus.done, 1'b0);
      check("kv_hold", bus.keys_valid, 1'b1);
      check("busy_idle", bus.busy, 1'b0);
      sweep(1'b0);
    end
  endtask

  logic [127:0] fips_key;
  logic [127:0] rnd_key;

  initial begin
    checks = 0;
    errors = 0;
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build_sbox();

    reset         = 1'b0;
    bus.key_in    = 128'h0123456789abcdef0123456789abcdef;
    bus.key_valid = 1'b1;
    bus.rk_addr   = 4'd0;
    step();
    step();
    check("rst_ready", bus.key_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_kv", bus.keys_valid, 1'b0);
    check("rst_rk_out", bus.rk_out, '0);
    bus.key_valid = 1'b0;
    reset = 1'b1;
    step();
    check("ready_after_rst", bus.key_ready, 1'b1);
    check("idle_busy", bus.busy, 1'b0);

    // FIPS-197 key with fixed known answers.
    present(fips_key);
    expand_and_check(fips_key, 1'b0, 1'b0, '0);
    bus.rk_addr = 4'd1;
    step();
    step();
    check("fips_rk1", bus.rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    bus.rk_addr = 4'd10;
    step();
    check("fips_rk10", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // key_valid held through EXPAND with a different key must be ignored.
    present(fips_key);
    expand_and_check(fips_key, 1'b1, 1'b0, '0);
    bus.rk_addr = 4'd10;
    step();
    check("hold_rk10", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key, then back-to-back zero key handshake in the DONE cycle.
    present('0);
    expand_and_check('0, 1'b0, 1'b1, '0);
    expand_and_check('0, 1'b0, 1'b0, '0);
    bus.rk_addr = 4'd10;
    step();
    check("zero_rk10", bus.rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    bus.rk_addr = 4'd0;
    step();
    check("zero_rk0", bus.rk_out, '0);

    // Reset in the middle of an expansion.
    present(fips_key);
    step();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    present(fips_key);
    step();
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_kv", bus.keys_valid, 1'b0);
    check("mid_rst_ready", bus.key_ready, 1'b0);
    check("mid_rst_rk_out", bus.rk_out, '0);
    bus.key_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready_rel", bus.key_ready, 1'b1);
    sweep(1'b1);
    check("mid_rst_idle_busy", bus.busy, 1'b0);

    // Random keys against the model.
    for (int n = 0; n < 3; n++) begin
      rnd_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      present(rnd_key);
      expand_and_check(rnd_key, 1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-002 Parameter: NUM_ROUNDS, default 10, number of expansion rounds; only 10 (AES-128) is supported.
REQ-003 Port: clk  input  1  rising-edge system clock.
REQ-004 Port: reset  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 Port: key_in  input  128  cipher key, bit 127 = byte 0 (FIPS-197 order).
REQ-006 Port: key_valid  input  1  key_in is offered this cycle.
REQ-007 Port: key_ready  output  1  block can accept a key this cycle.
REQ-008 Port: rk_addr  input  4  round-key index, 0..10.
REQ-009 Port: rk_out  output  128  registered round key for rk_addr.
REQ-010 Port: busy  output  1  expansion in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking schedule completion.
REQ-012 Port: keys_valid  output  1  level signal; round-key table is complete and coherent.

Function
REQ-013 The block SHALL hold an 11 x 128-bit round-key table (rk[0..10]) and a 4-bit round counter rnd.
REQ-014 The FSM SHALL have exactly three states: IDLE, EXPAND and DONE.
REQ-015 key_ready SHALL be 1 in IDLE and DONE, and 0 in EXPAND.
REQ-016 A handshake occurs when key_valid & key_ready are both high at a rising edge.
 - rk[0] <= key_in; rnd <= 1; keys_valid <= 0; state -> EXPAND.
REQ-017 key_valid while key_ready=0 SHALL be ignored: no state change, no buffering.
REQ-018 Each EXPAND cycle SHALL perform one single-round expansion (expand_key_core), writing rk[rnd] = expand(rk[rnd-1], rcon index rnd), then rnd <= rnd+1.
 - RotWord, SubWord, XOR of the top word with Rcon(rnd), then the 4-word XOR chain.
REQ-019 Exactly one round key SHALL be written per cycle.
 - Handshake at edge N: rk[k] is written at edge N+k for k = 1..10.
REQ-020 After rk[10] is written (edge N+10), state SHALL go to DONE and rnd SHALL return to 0.
REQ-021 done SHALL be high for exactly the one cycle following edge N+10.
REQ-022 keys_valid SHALL go high at edge N+10 and stay high until the next handshake or reset.
REQ-023 busy SHALL be 1 exactly while in EXPAND (10 cycles per key).
REQ-024 A handshake in DONE SHALL restart the schedule identically to one from IDLE.
 - keys_valid drops the same edge.
 - done is not reasserted until the new schedule completes.
REQ-025 rk_out SHALL be registered: rk_out <= rk[rk_addr] each edge (1-cycle read latency).
 - rk_addr > 10 SHALL yield rk_out <= 0.
REQ-026 Reads during EXPAND SHALL be permitted.
 - Entries not yet rewritten return stale data; validity is indicated only by keys_valid.
REQ-027 Rcon index SHALL always be in the range 1..10; rnd SHALL never exceed 10.

Reset
REQ-028 With reset=0 at an edge, the block SHALL apply, in any state including mid-EXPAND:
 - state <= IDLE; rnd <= 0; all rk[] <= 0.
 - rk_out <= 0; done, busy, keys_valid <= 0.
REQ-029 During reset key_ready SHALL read 0.
 - key_ready SHALL be 1 from the first cycle after reset releases.
 - A key_valid coincident with reset SHALL be discarded.

Verification
REQ-030 FIPS-197 key: handshake key_in=2b7e151628aed2a6abf7158809cf4f3c.
 - rk[1]=a0fafe1788542cb123a339392a6c7605.
 - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
 - done pulses at cycle N+11 only; busy high for 10 cycles.
REQ-031 All-zero key -> rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e; rk[0] reads back as 0.
REQ-032 key_valid held high through EXPAND with a different key -> ignored; FIPS-197 results unchanged; the next handshake is taken only in DONE.
REQ-033 Reset asserted at cycle N+5 -> the next cycle shows IDLE with all outputs 0, rk_out=0 for every address and key_ready=1; a new key then completes normally.
REQ-034 Back-to-back: handshake in the DONE cycle with the zero key -> keys_valid drops immediately and returns 10 cycles later with rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 rk_addr sweep 0..15 after completion -> rk_out matches the table one cycle later for addresses 0..10 and is 0 for 11..15.
